// File: rtl/riscv_csr_trap_unit.sv
// riscv_csr_trap_unit: machine-mode CSR file with trap/MRET commit and one-cycle PC redirect pulse
module riscv_csr_trap_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h00000100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_we,
  input  logic            csr_re,
  input  logic [2:0]      csr_funct3,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_bad_addr,
  input  logic            trap_req,
  input  logic [3:0]      trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  input  logic            instr_retire,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);
  typedef enum logic {RUN, REDIRECT} state_t;
  state_t state, state_n;
  logic mie, mpie, hit, run, take_trap, take_mret, do_write;
  logic [XLEN-1:0] mtvec, mscratch, mepc, wval;
  logic [3:0] mcause;
  logic [2*XLEN-1:0] mcycle, minstret;
  always_comb begin
    hit = 1'b1;
    csr_rdata = '0;
    case (csr_addr)
      12'h300: csr_rdata = XLEN'({mpie, 3'b000, mie, 3'b000});
      12'h305: csr_rdata = mtvec;
      12'h340: csr_rdata = mscratch;
      12'h341: csr_rdata = mepc;
      12'h342: csr_rdata = XLEN'(mcause);
      12'hB00: csr_rdata = mcycle[XLEN-1:0];
      12'hB80: csr_rdata = mcycle[2*XLEN-1:XLEN];
      12'hB02: csr_rdata = minstret[XLEN-1:0];
      12'hB82: csr_rdata = minstret[2*XLEN-1:XLEN];
      default: hit = 1'b0;
    endcase
  end
  assign csr_bad_addr = (csr_re | csr_we) & ~hit;
  always_comb begin
    run = state == RUN;
    take_trap = run & trap_req;
    take_mret = run & mret & ~trap_req;
    do_write = run & csr_we & ~trap_req & ~mret & hit & (csr_funct3 == 3'b001 | csr_funct3 == 3'b010);
    wval = csr_funct3 == 3'b001 ? csr_wdata : csr_rdata | csr_wdata;
    state_n = (take_trap | take_mret) ? REDIRECT : RUN;
  end
  assign redirect_valid = state == REDIRECT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      mie <= 1'b0;
      mpie <= 1'b0;
      mtvec <= RESET_MTVEC;
      mscratch <= '0;
      mepc <= '0;
      mcause <= '0;
      mcycle <= '0;
      minstret <= '0;
      redirect_pc <= '0;
    end else begin
      state <= state_n;
      mcycle <= mcycle + 1'b1;
      if (run & instr_retire & ~trap_req) minstret <= minstret + 1'b1;
      if (take_trap) begin
        mepc <= trap_pc & ~XLEN'(3);
        mcause <= trap_cause;
        mpie <= mie;
        mie <= 1'b0;
        redirect_pc <= mtvec;
      end else if (take_mret) begin
        mie <= mpie;
        mpie <= 1'b1;
        redirect_pc <= mepc;
      end else if (do_write) begin
        case (csr_addr)
          12'h300: begin mie <= wval[3]; mpie <= wval[7]; end
          12'h305: mtvec <= wval & ~XLEN'(3);
          12'h340: mscratch <= wval;
          12'h341: mepc <= wval & ~XLEN'(3);
          12'h342: mcause <= wval[3:0];
          12'hB00: mcycle <= {mcycle[2*XLEN-1:XLEN], wval};
          12'hB80: mcycle <= {wval, mcycle[XLEN-1:0]};
          12'hB02: minstret <= {minstret[2*XLEN-1:XLEN], wval};
          12'hB82: minstret <= {wval, minstret[XLEN-1:0]};
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_riscv_csr_trap_unit.sv
// tb_riscv_csr_trap_unit: directed and randomized checks against a CSR-level reference model
module tb_riscv_csr_trap_unit;
  logic clk = 0, rst = 1, csr_we, csr_re, trap_req, mret, instr_retire;
  logic [2:0] csr_funct3;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, trap_pc, redirect_pc;
  logic [3:0] trap_cause;
  logic csr_bad_addr, redirect_valid;
  int checks = 0, errors = 0;
  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_rpc;
  logic [63:0] m_cyc, m_ret;
  bit m_redir;
  logic [11:0] addrs [10] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0};

  riscv_csr_trap_unit dut (
    .clk(clk), .rst(rst), .csr_we(csr_we), .csr_re(csr_re), .csr_funct3(csr_funct3),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_bad_addr(csr_bad_addr),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .mret(mret),
    .instr_retire(instr_retire), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic bit mok(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82};
  endfunction

  function automatic logic [31:0] mread(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ret[31:0];
      12'hB82: return m_ret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic mreset();
    m_mstatus = 0; m_mtvec = 32'h100; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_rpc = 0; m_cyc = 0; m_ret = 0; m_redir = 0;
  endtask

  task automatic mstep();
    logic [63:0] nc, nr;
    logic [31:0] v, old;
    bit run;
    if (rst) begin mreset(); return; end
    run = !m_redir;
    old = mread(csr_addr);
    nc = m_cyc + 1;
    nr = m_ret + ((run && instr_retire && !trap_req) ? 64'd1 : 64'd0);
    m_redir = 0;
    if (run && trap_req) begin
      m_mepc = trap_pc & ~32'h3;
      m_mcause = {28'h0, trap_cause};
      m_rpc = m_mtvec;
      m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
      m_redir = 1;
    end else if (run && mret) begin
      m_rpc = m_mepc;
      m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
      m_redir = 1;
    end else if (run && csr_we && mok(csr_addr) && (csr_funct3 == 3'd1 || csr_funct3 == 3'd2)) begin
      v = csr_funct3 == 3'd1 ? csr_wdata : old | csr_wdata;
      case (csr_addr)
        12'h300: m_mstatus = v & 32'h88;
        12'h305: m_mtvec = v & ~32'h3;
        12'h340: m_mscratch = v;
        12'h341: m_mepc = v & ~32'h3;
        12'h342: m_mcause = v & 32'hF;
        12'hB00: nc = {m_cyc[63:32], v};
        12'hB80: nc = {v, m_cyc[31:0]};
        12'hB02: nr = {m_ret[63:32], v};
        12'hB82: nr = {v, m_ret[31:0]};
        default: ;
      endcase
    end
    m_cyc = nc;
    m_ret = nr;
  endtask

  task automatic idle();
    csr_we = 0; csr_re = 0; csr_funct3 = 0; csr_addr = 0; csr_wdata = 0;
    trap_req = 0; trap_cause = 0; trap_pc = 0; mret = 0; instr_retire = 0;
  endtask

  task automatic cyc();
    #1;
    mstep();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_re = 1; csr_addr = a; #1;
  endtask

  task automatic wr(input logic [2:0] f, input logic [11:0] a, input logic [31:0] d);
    csr_we = 1; csr_funct3 = f; csr_addr = a; csr_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1; idle(); cyc(); cyc(); rst = 0;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redirect_valid: got %b expected 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc); end
    rd(12'h305);
    checks++; if (csr_rdata !== 32'h100) begin errors++; $display("FAIL reset_mtvec: got %h expected 100", csr_rdata); end
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL reset_mstatus: got %h expected 0", csr_rdata); end
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL reset_mcycle: got %h expected 0", csr_rdata); end
    idle();
    repeat (5) cyc();
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'd5) begin errors++; $display("FAIL mcycle_after5: got %h expected 5", csr_rdata); end
    idle();
  endtask

  task automatic test_csr_rw();
    wr(3'b001, 12'h340, 32'hDEADBEEF); #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL csrrw_old: got %h expected 0", csr_rdata); end
    cyc(); idle(); rd(12'h340);
    checks++; if (csr_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL csrrw_new: got %h expected deadbeef", csr_rdata); end
    idle(); wr(3'b010, 12'h340, 32'h10); cyc(); idle(); rd(12'h340);
    checks++; if (csr_rdata !== 32'hDEADBEFF) begin errors++; $display("FAIL csrrs: got %h expected deadbeff", csr_rdata); end
    idle(); wr(3'b011, 12'h340, 32'h0); cyc(); idle(); rd(12'h340);
    checks++; if (csr_rdata !== 32'hDEADBEFF) begin errors++; $display("FAIL funct3_nowrite: got %h expected deadbeff", csr_rdata); end
    idle();
  endtask

  task automatic test_trap();
    wr(3'b001, 12'h300, 32'h8); cyc(); idle();
    trap_req = 1; trap_cause = 2; trap_pc = 32'h44; cyc(); idle(); #1;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL trap_pulse: got %b expected 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL trap_pc: got %h expected 100", redirect_pc); end
    rd(12'h341);
    checks++; if (csr_rdata !== 32'h44) begin errors++; $display("FAIL trap_mepc: got %h expected 44", csr_rdata); end
    rd(12'h342);
    checks++; if (csr_rdata !== 32'h2) begin errors++; $display("FAIL trap_mcause: got %h expected 2", csr_rdata); end
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h80) begin errors++; $display("FAIL trap_mstatus: got %h expected 80", csr_rdata); end
    idle(); cyc();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL trap_pulse_len: got %b expected 0", redirect_valid); end
  endtask

  task automatic test_mret();
    mret = 1; cyc(); idle(); #1;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL mret_pulse: got %b expected 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h44) begin errors++; $display("FAIL mret_pc: got %h expected 44", redirect_pc); end
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h88) begin errors++; $display("FAIL mret_mstatus: got %h expected 88", csr_rdata); end
    idle(); cyc();
  endtask

  task automatic test_priority();
    trap_req = 1; trap_cause = 2; trap_pc = 32'h50; wr(3'b001, 12'h305, 32'h200); cyc(); idle(); #1;
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL prio_trap_pc: got %h expected 100", redirect_pc); end
    cyc(); rd(12'h305);
    checks++; if (csr_rdata !== 32'h100) begin errors++; $display("FAIL prio_mtvec: got %h expected 100", csr_rdata); end
    idle(); trap_req = 1; trap_cause = 2; trap_pc = 32'h60; mret = 1; cyc(); idle(); #1;
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL prio_mret_pc: got %h expected 100", redirect_pc); end
    rd(12'h341);
    checks++; if (csr_rdata !== 32'h60) begin errors++; $display("FAIL prio_mret_mepc: got %h expected 60", csr_rdata); end
    rd(12'h300);
    checks++; if (csr_rdata !== mread(12'h300)) begin errors++; $display("FAIL prio_mret_mstatus: got %h expected %h", csr_rdata, mread(12'h300)); end
    idle(); cyc();
  endtask

  task automatic test_back_to_back();
    trap_req = 1; trap_cause = 2; trap_pc = 32'h70; cyc();
    trap_pc = 32'h74; cyc(); idle(); #1;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL held_trap_pulse: got %b expected 0", redirect_valid); end
    rd(12'h341);
    checks++; if (csr_rdata !== 32'h70) begin errors++; $display("FAIL held_trap_mepc: got %h expected 70", csr_rdata); end
    idle();
  endtask

  task automatic test_counters();
    logic [31:0] h;
    h = m_cyc[63:32];
    wr(3'b001, 12'hB00, 32'hFFFFFFFF); cyc(); idle(); rd(12'hB00);
    checks++; if (csr_rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL mcycle_write: got %h expected ffffffff", csr_rdata); end
    idle(); cyc(); rd(12'hB00);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mcycle_carry_lo: got %h expected 0", csr_rdata); end
    rd(12'hB80);
    checks++; if (csr_rdata !== h + 32'd1) begin errors++; $display("FAIL mcycle_carry_hi: got %h expected %h", csr_rdata, h + 32'd1); end
    idle(); wr(3'b001, 12'hB80, 32'hFFFFFFFF); cyc(); wr(3'b001, 12'hB00, 32'hFFFFFFFF); cyc(); idle(); cyc(); rd(12'hB80);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mcycle_wrap_hi: got %h expected 0", csr_rdata); end
    rd(12'h7C0); csr_we = 1;
    checks++; if (csr_bad_addr !== 1'b1) begin errors++; $display("FAIL bad_addr_flag: got %b expected 1", csr_bad_addr); end
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL bad_addr_rdata: got %h expected 0", csr_rdata); end
    idle();
  endtask

  task automatic test_reset_in_redirect();
    trap_req = 1; trap_cause = 3; trap_pc = 32'h90; cyc(); idle();
    rst = 1; cyc(); rst = 0; #1;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_redirect_pulse: got %b expected 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect_pc: got %h expected 0", redirect_pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 59) == 0;
      csr_we = $urandom_range(0, 1);
      csr_re = $urandom_range(0, 1);
      csr_funct3 = 3'($urandom_range(0, 3));
      csr_addr = addrs[$urandom_range(0, 9)];
      csr_wdata = $urandom_range(0, 3) == 0 ? 32'h0 : $urandom;
      trap_req = $urandom_range(0, 9) == 0;
      trap_cause = 4'($urandom);
      trap_pc = $urandom;
      mret = $urandom_range(0, 9) == 0;
      instr_retire = $urandom_range(0, 1);
      #1;
      checks++; if (csr_rdata !== mread(csr_addr)) begin errors++; $display("FAIL rand_rdata[%0d] addr %h: got %h expected %h", i, csr_addr, csr_rdata, mread(csr_addr)); end
      checks++; if (csr_bad_addr !== ((csr_re || csr_we) && !mok(csr_addr))) begin errors++; $display("FAIL rand_bad_addr[%0d]: got %b", i, csr_bad_addr); end
      checks++; if (redirect_valid !== m_redir) begin errors++; $display("FAIL rand_redirect_valid[%0d]: got %b expected %b", i, redirect_valid, m_redir); end
      checks++; if (redirect_pc !== m_rpc) begin errors++; $display("FAIL rand_redirect_pc[%0d]: got %h expected %h", i, redirect_pc, m_rpc); end
      cyc();
    end
    rst = 0; idle();
  endtask

  initial begin
    idle();
    @(posedge clk); #1;
    test_reset();
    test_csr_rw();
    test_trap();
    test_mret();
    test_priority();
    test_back_to_back();
    test_counters();
    test_reset_in_redirect();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
